// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: load-use stalls, redirect flushes, dmem wait/timeout.
// Optional performance counters (stall_cnt, flush_cnt) are built when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             mem_access,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clr,
  output logic             idex_en,
  output logic             idex_clr,
  output logic             exmem_en,
  output logic             exmem_clr,
  output logic             memwb_en,
  output logic             memwb_clr,
  output logic             mem_fault
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_e;

  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);

  state_e      state;
  state_e      state_next;
  logic [15:0] wait_cnt;
  logic [15:0] wait_cnt_next;
  logic        lu;
  logic        mstall;

  assign lu = ex_is_load && (ex_rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  assign mstall = ((state == RUN) && mem_access && !dmem_ack) ||
                  ((state == MEM_WAIT) && !dmem_ack) ||
                  (state == FAULT);

  assign mem_fault = (state == FAULT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= 16'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // An ack on the timeout cycle itself wins over the fault.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      RUN: begin
        if (mem_access && !dmem_ack) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = 16'd1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack) begin
          state_next    = RUN;
          wait_cnt_next = 16'd0;
        end else if (wait_cnt == TIMEOUT) begin
          state_next = FAULT;
        end else if (wait_cnt != 16'hFFFF) begin
          wait_cnt_next = wait_cnt + 16'd1;
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = 16'd0;
      end
    endcase
  end

  always_comb begin
    dmem_req  = 1'b0;
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    ifid_clr  = 1'b0;
    idex_en   = 1'b1;
    idex_clr  = 1'b0;
    exmem_en  = 1'b1;
    exmem_clr = 1'b0;
    memwb_en  = 1'b1;
    memwb_clr = 1'b0;
    if (reset) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      ifid_clr  = 1'b1;
      idex_en   = 1'b0;
      idex_clr  = 1'b1;
      exmem_en  = 1'b0;
      exmem_clr = 1'b1;
      memwb_en  = 1'b0;
      memwb_clr = 1'b1;
    end else begin
      dmem_req = mem_access && (state != FAULT);
      if (mstall) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end else if (ex_redirect) begin
        ifid_clr = 1'b1;
        idex_clr = 1'b1;
      end else if (lu) begin
        // Hold PC and IF/ID; the clear turns the ID/EX load into a bubble.
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_clr = 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (mstall || (lu && !ex_redirect)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (ex_redirect && !mstall) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic unused_perf;
  assign unused_perf = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (TIMEOUT_CYCLES = 4); expected control vectors are queued per cycle.
// Counter checks are included when PIPE_CTRL_PERF_EN is defined.
module tb_pipe_hazard_ctrl;

  localparam logic LO = 1'b0;
  localparam logic HI = 1'b1;

  typedef enum logic [2:0] {M_RESET, M_FREEZE, M_REDIR, M_LU, M_NORMAL} mode_e;

  typedef struct {
    logic       rst;
    logic       load;
    logic [4:0] rd;
    logic       use1;
    logic [4:0] rs1;
    logic       use2;
    logic [4:0] rs2;
    logic       redir;
    logic       macc;
    logic       ack;
    mode_e      mode;
    logic       req;
    logic       fault;
    logic       chk;
  } stim_t;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_is_load, ex_redirect, mem_access, dmem_ack;
  logic        dmem_req, pc_en, ifid_en, ifid_clr, idex_en, idex_clr;
  logic        exmem_en, exmem_clr, memwb_en, memwb_clr, mem_fault;
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif
  logic [10:0] outs;

  int checks = 0;
  int fails  = 0;
  logic [10:0] exp_q[$];

  pipe_hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .mem_access(mem_access), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr),
    .idex_en(idex_en), .idex_clr(idex_clr), .exmem_en(exmem_en), .exmem_clr(exmem_clr),
    .memwb_en(memwb_en), .memwb_clr(memwb_clr), .mem_fault(mem_fault)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  assign outs = {dmem_req, pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
                 exmem_en, exmem_clr, memwb_en, memwb_clr, mem_fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(input logic rst, input logic load, input logic [4:0] rd,
                               input logic use1, input logic [4:0] rs1,
                               input logic use2, input logic [4:0] rs2,
                               input logic redir, input logic macc, input logic ack,
                               input mode_e mode, input logic req, input logic fault,
                               input logic chk);
    stim_t s;
    s.rst = rst; s.load = load; s.rd = rd; s.use1 = use1; s.rs1 = rs1;
    s.use2 = use2; s.rs2 = rs2; s.redir = redir; s.macc = macc; s.ack = ack;
    s.mode = mode; s.req = req; s.fault = fault; s.chk = chk;
    return s;
  endfunction

  // Control order: pc_en ifid_en ifid_clr idex_en idex_clr exmem_en exmem_clr memwb_en memwb_clr.
  function automatic logic [10:0] model(input stim_t s);
    logic [8:0] ctl;
    case (s.mode)
      M_RESET:  ctl = 9'b001010101;
      M_FREEZE: ctl = 9'b000000000;
      M_REDIR:  ctl = 9'b111111010;
      M_LU:     ctl = 9'b000111010;
      default:  ctl = 9'b110101010;
    endcase
    return {s.req, ctl, s.fault};
  endfunction

  task automatic apply(input stim_t s);
    reset = s.rst; ex_is_load = s.load; ex_rd = s.rd;
    id_use_rs1 = s.use1; id_rs1 = s.rs1; id_use_rs2 = s.use2; id_rs2 = s.rs2;
    ex_redirect = s.redir; mem_access = s.macc; dmem_ack = s.ack;
    if (s.chk) exp_q.push_back(model(s));
  endtask

  task automatic test_reset();
    stim_t rows[$];
    logic [10:0] got, want;
    rows.push_back(mk(HI, LO, 5'd0, LO, 5'd0, LO, 5'd0, HI, HI, LO, M_RESET, LO, LO, HI));
    rows.push_back(mk(HI, HI, 5'd3, HI, 5'd3, LO, 5'd0, LO, LO, LO, M_RESET, LO, LO, HI));
    foreach (rows[i]) begin
      apply(rows[i]);
      #2;
      got = outs; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL reset row %0d: got %b expected %b", i, got, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_use();
    stim_t rows[$];
    logic [10:0] got, want;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] s0;
    s0 = stall_cnt;
`endif
    rows.push_back(mk(LO, HI, 5'd5,  LO, 5'd0,  HI, 5'd5,  LO, LO, LO, M_LU,     LO, LO, HI));
    rows.push_back(mk(LO, LO, 5'd5,  LO, 5'd0,  HI, 5'd5,  LO, LO, LO, M_NORMAL, LO, LO, HI));
    rows.push_back(mk(LO, HI, 5'd0,  LO, 5'd0,  HI, 5'd0,  LO, LO, LO, M_NORMAL, LO, LO, HI));
    rows.push_back(mk(LO, HI, 5'd7,  HI, 5'd7,  LO, 5'd0,  LO, LO, LO, M_LU,     LO, LO, HI));
    rows.push_back(mk(LO, HI, 5'd7,  LO, 5'd7,  HI, 5'd3,  LO, LO, LO, M_NORMAL, LO, LO, HI));
    rows.push_back(mk(LO, HI, 5'd31, HI, 5'd31, HI, 5'd31, LO, LO, LO, M_LU,     LO, LO, HI));
    foreach (rows[i]) begin
      apply(rows[i]);
      #2;
      got = outs; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL load_use row %0d: got %b expected %b", i, got, want);
      end
      @(negedge clk);
    end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (16'(stall_cnt - s0) !== 16'd3) begin
      fails++;
      $display("[TB] FAIL load_use stall_cnt delta: got %0d expected 3", 16'(stall_cnt - s0));
    end
`endif
  endtask

  task automatic test_redirect();
    stim_t rows[$];
    logic [10:0] got, want;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] f0;
    f0 = flush_cnt;
`endif
    rows.push_back(mk(LO, HI, 5'd5, LO, 5'd0, HI, 5'd5, HI, LO, LO, M_REDIR,  LO, LO, HI));
    rows.push_back(mk(LO, LO, 5'd0, LO, 5'd0, LO, 5'd0, HI, LO, LO, M_REDIR,  LO, LO, HI));
    rows.push_back(mk(LO, LO, 5'd0, LO, 5'd0, LO, 5'd0, LO, LO, LO, M_NORMAL, LO, LO, HI));
    foreach (rows[i]) begin
      apply(rows[i]);
      #2;
      got = outs; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL redirect row %0d: got %b expected %b", i, got, want);
      end
      @(negedge clk);
    end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (16'(flush_cnt - f0) !== 16'd2) begin
      fails++;
      $display("[TB] FAIL redirect flush_cnt delta: got %0d expected 2", 16'(flush_cnt - f0));
    end
`endif
  endtask

  task automatic test_mem_wait();
    stim_t rows[$];
    logic [10:0] got, want;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] s0;
    s0 = stall_cnt;
`endif
    for (int k = 0; k < 3; k++)
      rows.push_back(mk(LO, LO, 5'd0, LO, 5'd0, LO, 5'd0, LO, HI, LO, M_FREEZE, HI, LO, HI));
    rows.push_back(mk(LO, LO, 5'd0, LO, 5'd0, LO, 5'd0, LO, HI, HI, M_NORMAL, HI, LO, HI));
    rows.push_back(mk(LO, LO, 5'd0, LO, 5'd0, LO, 5'd0, LO, LO, LO, M_NORMAL, LO, LO, HI));
    rows.push_back(mk(LO, LO, 5'd0, LO, 5'd0, LO, 5'd0, LO, HI, HI, M_NORMAL, HI, LO, HI));
    rows.push_back(mk(LO, LO, 5'd0, LO, 5'd0, LO, 5'd0, LO, LO, HI, M_NORMAL, LO, LO, HI));
    foreach (rows[i]) begin
      apply(rows[i]);
      #2;
      got = outs; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL mem_wait row %0d: got %b expected %b", i, got, want);
      end
      @(negedge clk);
    end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (16'(stall_cnt - s0) !== 16'd3) begin
      fails++;
      $display("[TB] FAIL mem_wait stall_cnt delta: got %0d expected 3", 16'(stall_cnt - s0));
    end
`endif
  endtask

  task automatic test_timeout_ack();
    stim_t rows[$];
    logic [10:0] got, want;
    for (int k = 0; k < 4; k++)
      rows.push_back(mk(LO, LO, 5'd0, LO, 5'd0, LO, 5'd0, LO, HI, LO, M_FREEZE, HI, LO, HI));
    rows.push_back(mk(LO, LO, 5'd0, LO, 5'd0, LO, 5'd0, LO, HI, HI, M_NORMAL, HI, LO, HI));
    rows.push_back(mk(LO, LO, 5'd0, LO, 5'd0, LO, 5'd0, LO, LO, LO, M_NORMAL, LO, LO, HI));
    foreach (rows[i]) begin
      apply(rows[i]);
      #2;
      got = outs; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL timeout_ack row %0d: got %b expected %b", i, got, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_simultaneous();
    stim_t rows[$];
    logic [10:0] got, want;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] f0;
    f0 = flush_cnt;
`endif
    rows.push_back(mk(LO, HI, 5'd5, LO, 5'd0, HI, 5'd5, HI, HI, LO, M_FREEZE, HI, LO, HI));
    rows.push_back(mk(LO, HI, 5'd5, LO, 5'd0, HI, 5'd5, HI, HI, LO, M_FREEZE, HI, LO, HI));
    rows.push_back(mk(LO, HI, 5'd5, LO, 5'd0, HI, 5'd5, HI, HI, HI, M_REDIR,  HI, LO, HI));
    rows.push_back(mk(LO, LO, 5'd0, LO, 5'd0, LO, 5'd0, LO, LO, LO, M_NORMAL, LO, LO, HI));
    foreach (rows[i]) begin
      apply(rows[i]);
      #2;
      got = outs; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL simultaneous row %0d: got %b expected %b", i, got, want);
      end
      @(negedge clk);
    end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (16'(flush_cnt - f0) !== 16'd1) begin
      fails++;
      $display("[TB] FAIL simultaneous flush_cnt delta: got %0d expected 1", 16'(flush_cnt - f0));
    end
`endif
  endtask

  task automatic test_reset_mid_wait();
    stim_t rows[$];
    logic [10:0] got, want;
    rows.push_back(mk(LO, LO, 5'd0, LO, 5'd0, LO, 5'd0, LO, HI, LO, M_FREEZE, HI, LO, HI));
    rows.push_back(mk(LO, LO, 5'd0, LO, 5'd0, LO, 5'd0, LO, HI, LO, M_FREEZE, HI, LO, HI));
    rows.push_back(mk(HI, LO, 5'd0, LO, 5'd0, LO, 5'd0, LO, HI, LO, M_RESET,  LO, LO, HI));
    rows.push_back(mk(LO, LO, 5'd0, LO, 5'd0, LO, 5'd0, LO, LO, LO, M_NORMAL, LO, LO, HI));
    foreach (rows[i]) begin
      apply(rows[i]);
      #2;
      got = outs; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL reset_mid_wait row %0d: got %b expected %b", i, got, want);
      end
      @(negedge clk);
    end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if ((stall_cnt !== 16'd0) || (flush_cnt !== 16'd0)) begin
      fails++;
      $display("[TB] FAIL reset_mid_wait counters: got stall %0d flush %0d expected 0 0",
               stall_cnt, flush_cnt);
    end
`endif
  endtask

  task automatic test_fault();
    stim_t rows[$];
    logic [10:0] got, want;
    for (int k = 0; k < 5; k++)
      rows.push_back(mk(LO, LO, 5'd0, LO, 5'd0, LO, 5'd0, LO, HI, LO, M_FREEZE, HI, LO, HI));
    rows.push_back(mk(LO, LO, 5'd0, LO, 5'd0, LO, 5'd0, LO, HI, LO, M_FREEZE, LO, HI, HI));
    rows.push_back(mk(LO, LO, 5'd0, LO, 5'd0, LO, 5'd0, LO, HI, HI, M_FREEZE, LO, HI, HI));
    rows.push_back(mk(LO, HI, 5'd5, LO, 5'd0, HI, 5'd5, HI, LO, LO, M_FREEZE, LO, HI, HI));
    rows.push_back(mk(HI, LO, 5'd0, LO, 5'd0, LO, 5'd0, LO, LO, LO, M_RESET,  LO, LO, LO));
    rows.push_back(mk(HI, LO, 5'd0, LO, 5'd0, LO, 5'd0, LO, LO, LO, M_RESET,  LO, LO, HI));
    rows.push_back(mk(LO, LO, 5'd0, LO, 5'd0, LO, 5'd0, LO, LO, LO, M_NORMAL, LO, LO, HI));
    foreach (rows[i]) begin
      apply(rows[i]);
      #2;
      if (rows[i].chk) begin
        got = outs; want = exp_q.pop_front(); checks++;
        if (got !== want) begin
          fails++;
          $display("[TB] FAIL fault row %0d: got %b expected %b", i, got, want);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; ex_is_load = 1'b0; ex_rd = 5'd0; id_use_rs1 = 1'b0; id_rs1 = 5'd0;
    id_use_rs2 = 1'b0; id_rs2 = 5'd0; ex_redirect = 1'b0; mem_access = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout_ack();
    test_simultaneous();
    test_reset_mid_wait();
    test_fault();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
